// File: rtl/sdram_frame_scheduler_pkg.sv
// Shared types for the SDRAM frame scheduler and the memory controller it drives.
package sdram_frame_scheduler_pkg;

  // Command bus encoding seen by the SDRAM controller.
  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2
  } cmd_e;

  // Scheduler FSM states; encoded so each state matches its command value.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 22;
  localparam int BUF_W  = 2;
  localparam int DROP_W = 8;

  // Map a scheduler state onto the controller command bus.
  function automatic cmd_e state_to_cmd(input state_e s);
    cmd_e c;
    case (s)
      ST_WRITE: c = CMD_WRITE;
      ST_READ:  c = CMD_READ;
      default:  c = CMD_IDLE;
    endcase
    return c;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sdram_frame_scheduler_frame_buffer_rotator.sv
// Triple-buffer rotation and frame offsets for the camera (write) and
// display (read) sides. Write side always lands in the buffer that is
// neither being displayed nor holding the latest complete frame.
module frame_buffer_rotator
  import sdram_frame_scheduler_pkg::*;
#(
  parameter int BURST_LENGTH = 8,
  parameter int FRAME_WORDS  = 153600,
  parameter int OFF_W        = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              in_write,
  input  logic              wr_burst_end,
  input  logic              rd_burst_end,
  output logic [BUF_W-1:0]  wr_buf,
  output logic [BUF_W-1:0]  rd_buf,
  output logic [OFF_W-1:0]  wr_offset,
  output logic [OFF_W-1:0]  rd_offset,
  output logic [DROP_W-1:0] frames_dropped
);

  localparam logic [OFF_W:0] FW_X = (OFF_W + 1)'(FRAME_WORDS);
  localparam logic [OFF_W:0] BL_X = (OFF_W + 1)'(BURST_LENGTH);

  logic [BUF_W-1:0]  wr_buf_q, wr_buf_d;
  logic [BUF_W-1:0]  rd_buf_q, rd_buf_d;
  logic [BUF_W-1:0]  latest_q, latest_d;
  logic [OFF_W-1:0]  wr_off_q, wr_off_d;
  logic [OFF_W-1:0]  rd_off_q, rd_off_d;
  logic [DROP_W-1:0] drops_q, drops_d;
  logic              pend_q, pend_d;
  logic              drop_hit;
  logic [OFF_W:0]    wr_next;
  logic [OFF_W:0]    rd_next;
  logic              wr_wrap;
  logic              rd_wrap;

  // One extra bit so the end-of-frame value is representable before wrapping.
  assign wr_next = {1'b0, wr_off_q} + BL_X;
  assign rd_next = {1'b0, rd_off_q} + BL_X;
  assign wr_wrap = (wr_next == FW_X);
  assign rd_wrap = (rd_next == FW_X);

  // Next-state rules for offsets, buffer indices, resync flag and drop counter.
  always_comb begin
    wr_buf_d = wr_buf_q;
    rd_buf_d = rd_buf_q;
    latest_d = latest_q;
    wr_off_d = wr_off_q;
    rd_off_d = rd_off_q;
    pend_d   = pend_q;
    drops_d  = drops_q;
    drop_hit = 1'b0;

    if (in_write) begin
      if (wr_burst_end) begin
        if (wr_wrap) begin
          // Frame completed: publish it and move to the free buffer. A
          // coinciding frame_start is satisfied by the wrap itself.
          latest_d = wr_buf_q;
          wr_buf_d = 2'd3 - wr_buf_q - rd_buf_q;
          wr_off_d = '0;
          pend_d   = 1'b0;
        end else if (pend_q || frame_start) begin
          // Camera restarted mid-frame: rewrite the same buffer from the top.
          wr_off_d = '0;
          pend_d   = 1'b0;
          drop_hit = 1'b1;
        end else begin
          wr_off_d = wr_next[OFF_W-1:0];
        end
      end else if (frame_start) begin
        // Address must stay fixed during a burst; defer until it ends.
        pend_d = 1'b1;
      end
    end else if (pend_q || frame_start) begin
      drop_hit = (wr_off_q != '0);
      wr_off_d = '0;
      pend_d   = 1'b0;
    end

    if (rd_burst_end) begin
      if (rd_wrap) begin
        rd_off_d = '0;
        rd_buf_d = latest_q;
      end else begin
        rd_off_d = rd_next[OFF_W-1:0];
      end
    end

    if (drop_hit && (drops_q != {DROP_W{1'b1}})) begin
      drops_d = drops_q + 8'd1;
    end
  end

  // Register rotation state; buffer 1 starts as the write target.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_buf_q <= 2'd1;
      rd_buf_q <= 2'd0;
      latest_q <= 2'd0;
      wr_off_q <= '0;
      rd_off_q <= '0;
      drops_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      wr_buf_q <= wr_buf_d;
      rd_buf_q <= rd_buf_d;
      latest_q <= latest_d;
      wr_off_q <= wr_off_d;
      rd_off_q <= rd_off_d;
      drops_q  <= drops_d;
      pend_q   <= pend_d;
    end
  end

  assign wr_buf         = wr_buf_q;
  assign rd_buf         = rd_buf_q;
  assign wr_offset      = wr_off_q;
  assign rd_offset      = rd_off_q;
  assign frames_dropped = drops_q;

endmodule

// File: rtl/sdram_frame_scheduler.sv
// Arbitrates SDRAM bursts between the camera write FIFO and the display read
// FIFO, and forms burst addresses inside a triple-buffered frame store.
//
// Handshake: a burst is owned by the scheduler from the cycle command leaves
// IDLE; every cycle the controller asserts data_write_done (write) or
// data_read_valid (read) moves exactly one word, popped/pushed on the FIFO in
// that same cycle. The burst ends on the BURST_LENGTH-th such cycle.
module sdram_frame_scheduler
  import sdram_frame_scheduler_pkg::*;
#(
  parameter int BURST_LENGTH  = 8,
  parameter int FRAME_WORDS   = 153600,
  parameter int POINTER_WIDTH = 8,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [POINTER_WIDTH-1:0] wr_used,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  input  logic [POINTER_WIDTH-1:0] rd_used,
  output logic                     rd_enable,
  output logic [DATA_W-1:0]        rd_data,
  output logic [1:0]               command,
  output logic [ADDR_W-1:0]        data_address,
  output logic [DATA_W-1:0]        data_write,
  input  logic [DATA_W-1:0]        data_read,
  input  logic                     data_read_valid,
  input  logic                     data_write_done,
  output logic [BUF_W-1:0]         rd_buffer,
  output logic [DROP_W-1:0]        frames_dropped
);

  localparam int BCNT_W   = clog2_min1(BURST_LENGTH);
  localparam int OFF_W    = clog2_min1(FRAME_WORDS);
  localparam int STARVE_W = clog2_min1(STARVE_LIMIT + 1);

  localparam logic [BCNT_W-1:0]      BL_LAST    = BCNT_W'(BURST_LENGTH - 1);
  localparam logic [STARVE_W-1:0]    STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [POINTER_WIDTH:0] BL_PW      = (POINTER_WIDTH + 1)'(BURST_LENGTH);
  // Below half full is the same as the fill-count MSB being clear.
  localparam logic [POINTER_WIDTH-1:0] RD_HALF  = {1'b1, {(POINTER_WIDTH-1){1'b0}}};
  localparam logic [ADDR_W-1:0]      FW_A       = ADDR_W'(FRAME_WORDS);

  state_e              state_q, state_d;
  cmd_e                command_q, command_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                wr_eligible;
  logic                rd_eligible;
  logic                wr_burst_end;
  logic                rd_burst_end;

  logic [BUF_W-1:0]    wr_buf;
  logic [BUF_W-1:0]    rd_buf;
  logic [OFF_W-1:0]    wr_offset;
  logic [OFF_W-1:0]    rd_offset;

  assign wr_eligible = ({1'b0, wr_used} >= BL_PW);
  assign rd_eligible = (rd_used < RD_HALF);

  // Base address of one of the three frame buffers.
  function automatic logic [ADDR_W-1:0] frame_base(input logic [BUF_W-1:0] b);
    logic [ADDR_W-1:0] base;
    case (b)
      2'd1:    base = FW_A;
      2'd2:    base = FW_A << 1;
      default: base = '0;
    endcase
    return base;
  endfunction

  // Arbitration, burst word counting and starvation tracking.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    starve_d     = starve_q;
    wr_burst_end = 1'b0;
    rd_burst_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bcnt_d = '0;
        if (starve_q >= STARVE_MAX) begin
          // Display side has waited long enough; force it in.
          state_d  = ST_READ;
          starve_d = '0;
        end else if (wr_eligible) begin
          state_d  = ST_WRITE;
          starve_d = rd_eligible ? (starve_q + 1'b1) : '0;
        end else if (rd_eligible) begin
          state_d  = ST_READ;
          starve_d = '0;
        end
      end
      ST_WRITE: begin
        if (data_write_done) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BL_LAST) begin
            state_d      = ST_IDLE;
            bcnt_d       = '0;
            wr_burst_end = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (data_read_valid) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BL_LAST) begin
            state_d      = ST_IDLE;
            bcnt_d       = '0;
            rd_burst_end = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    command_d = state_to_cmd(state_d);
  end

  // Scheduler FSM registers, including the registered command output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      command_q <= CMD_IDLE;
      bcnt_q    <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      command_q <= command_d;
      bcnt_q    <= bcnt_d;
      starve_q  <= starve_d;
    end
  end

  frame_buffer_rotator #(
    .BURST_LENGTH (BURST_LENGTH),
    .FRAME_WORDS  (FRAME_WORDS),
    .OFF_W        (OFF_W)
  ) u_rotator (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .in_write       (state_q == ST_WRITE),
    .wr_burst_end   (wr_burst_end),
    .rd_burst_end   (rd_burst_end),
    .wr_buf         (wr_buf),
    .rd_buf         (rd_buf),
    .wr_offset      (wr_offset),
    .rd_offset      (rd_offset),
    .frames_dropped (frames_dropped)
  );

  // Burst address: offsets only move at burst end, so it is stable per burst.
  always_comb begin
    data_address = '0;
    case (state_q)
      ST_WRITE: data_address = frame_base(wr_buf) + ADDR_W'(wr_offset);
      ST_READ:  data_address = frame_base(rd_buf) + ADDR_W'(rd_offset);
      default:  data_address = '0;
    endcase
  end

  // FIFO strobes follow the controller directly; a reset cycle abandons the burst.
  assign wr_ack     = (state_q == ST_WRITE) && data_write_done && !reset;
  assign rd_enable  = (state_q == ST_READ) && data_read_valid && !reset;
  assign data_write = wr_data;
  assign rd_data    = data_read;
  assign command    = command_q;
  assign rd_buffer  = rd_buf;

endmodule

// File: tb/tb_sdram_frame_scheduler.sv
// Directed bench: dut_a uses full-size frames, dut_b uses 64-word frames so
// buffer rotation can be reached quickly. Both see identical stimulus.
module tb_sdram_frame_scheduler;
  import sdram_frame_scheduler_pkg::*;

  localparam int BL   = 8;
  localparam int FW_A = 153600;
  localparam int FW_B = 64;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [7:0]  wr_used;
  logic [15:0] wr_data;
  logic [7:0]  rd_used;
  logic [15:0] data_read;
  logic        data_read_valid;
  logic        data_write_done;

  logic        wr_ack_a, wr_ack_b, rd_enable_a, rd_enable_b;
  logic [15:0] rd_data_a, rd_data_b, data_write_a, data_write_b;
  logic [1:0]  command_a, command_b, rd_buffer_a, rd_buffer_b;
  logic [21:0] data_address_a, data_address_b;
  logic [7:0]  frames_dropped_a, frames_dropped_b;

  int n_vec  = 0;
  int n_fail = 0;

  sdram_frame_scheduler dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .wr_used(wr_used), .wr_data(wr_data), .wr_ack(wr_ack_a),
    .rd_used(rd_used), .rd_enable(rd_enable_a), .rd_data(rd_data_a),
    .command(command_a), .data_address(data_address_a), .data_write(data_write_a),
    .data_read(data_read), .data_read_valid(data_read_valid),
    .data_write_done(data_write_done), .rd_buffer(rd_buffer_a),
    .frames_dropped(frames_dropped_a)
  );

  sdram_frame_scheduler #(.FRAME_WORDS(FW_B)) dut_b (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .wr_used(wr_used), .wr_data(wr_data), .wr_ack(wr_ack_b),
    .rd_used(rd_used), .rd_enable(rd_enable_b), .rd_data(rd_data_b),
    .command(command_b), .data_address(data_address_b), .data_write(data_write_b),
    .data_read(data_read), .data_read_valid(data_read_valid),
    .data_write_done(data_write_done), .rd_buffer(rd_buffer_b),
    .frames_dropped(frames_dropped_b)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard compare
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Driver: hold reset two cycles, release on a falling edge.
  task automatic apply_reset(input logic [7:0] wu, input logic [7:0] ru);
    reset = 1'b1;
    frame_start = 1'b0;
    data_write_done = 1'b0;
    data_read_valid = 1'b0;
    wr_used = wu;
    rd_used = ru;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver: wait for a grant, serve one full burst, confirm return to IDLE.
  task automatic do_burst(input logic [1:0] cmd, input logic [21:0] ea, input logic chk_b,
                          input logic [21:0] eb, input int fs_at, input string nm);
    int w;
    logic [15:0] d;
    w = 0;
    while (command_a !== cmd && w < 40) begin
      @(negedge clk);
      w++;
    end
    #1;
    check({nm, "_grant"}, command_a, cmd);
    check({nm, "_grant_b"}, command_b, cmd);
    for (int k = 0; k < BL; k++) begin
      d = 16'($urandom_range(0, 65535));
      frame_start = (k == fs_at);
      if (cmd == CMD_WRITE) begin
        wr_data = d;
        data_write_done = 1'b1;
      end else begin
        data_read = d;
        data_read_valid = 1'b1;
      end
      #1;
      if (cmd == CMD_WRITE) begin
        check({nm, "_wr_ack"}, wr_ack_a, 1);
        check({nm, "_data_write"}, data_write_a, d);
      end else begin
        check({nm, "_rd_enable"}, rd_enable_a, 1);
        check({nm, "_rd_data"}, rd_data_a, d);
      end
      check({nm, "_addr"}, data_address_a, ea);
      if (chk_b) check({nm, "_addr_b"}, data_address_b, eb);
      @(negedge clk);
    end
    frame_start = 1'b0;
    data_write_done = 1'b0;
    data_read_valid = 1'b0;
    #1;
    check({nm, "_end_idle"}, command_a, CMD_IDLE);
  endtask

  typedef struct {
    logic [7:0]  wu;
    logic [7:0]  ru;
    logic [1:0]  cmd;
    logic [21:0] addr_a;
    logic [21:0] addr_b;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int w;
    reset = 1'b1;
    frame_start = 1'b0;
    wr_used = '0;
    rd_used = '0;
    wr_data = '0;
    data_read = '0;
    data_read_valid = 1'b0;
    data_write_done = 1'b0;

    // Arbitration table: first decision out of IDLE after reset.
    vecs[0] = '{8'd8,   8'd0,   2'd1, 22'd153600, 22'd64};
    vecs[1] = '{8'd7,   8'd0,   2'd2, 22'd0,      22'd0};
    vecs[2] = '{8'd7,   8'd128, 2'd0, 22'd0,      22'd0};
    vecs[3] = '{8'd255, 8'd255, 2'd1, 22'd153600, 22'd64};
    vecs[4] = '{8'd0,   8'd127, 2'd2, 22'd0,      22'd0};
    vecs[5] = '{8'd0,   8'd128, 2'd0, 22'd0,      22'd0};
    vecs[6] = '{8'd8,   8'd128, 2'd1, 22'd153600, 22'd64};
    vecs[7] = '{8'd200, 8'd64,  2'd1, 22'd153600, 22'd64};

    // Reset state
    apply_reset(8'd0, 8'd128);
    #1;
    check("rst_command", command_a, 0);
    check("rst_rd_buffer", rd_buffer_a, 0);
    check("rst_dropped", frames_dropped_a, 0);
    check("rst_wr_ack", wr_ack_a, 0);
    check("rst_rd_enable", rd_enable_a, 0);
    check("rst_addr", data_address_a, 0);

    for (int i = 0; i < 8; i++) begin
      apply_reset(vecs[i].wu, vecs[i].ru);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_cmd", i), command_a, vecs[i].cmd);
      check($sformatf("vec%0d_cmd_b", i), command_b, vecs[i].cmd);
      check($sformatf("vec%0d_addr", i), data_address_a, vecs[i].addr_a);
      check($sformatf("vec%0d_addr_b", i), data_address_b, vecs[i].addr_b);
    end

    // Single write burst into buffer 1, then strobes gated while idle.
    apply_reset(8'd8, 8'd0);
    do_burst(CMD_WRITE, 22'd153600, 1'b1, 22'd64, -1, "s1_wr");
    wr_used = 8'd0;
    rd_used = 8'd128;
    data_write_done = 1'b1;
    data_read_valid = 1'b1;
    #1;
    check("s1_idle_wr_ack", wr_ack_a, 0);
    check("s1_idle_rd_enable", rd_enable_a, 0);
    data_write_done = 1'b0;
    data_read_valid = 1'b0;
    @(negedge clk);
    #1;
    check("s1_parked", command_a, CMD_IDLE);

    // Starvation: four writes, then a forced read, then writing resumes.
    apply_reset(8'd200, 8'd0);
    for (int i = 0; i < 4; i++)
      do_burst(CMD_WRITE, 22'(153600 + 8 * i), 1'b1, 22'(64 + 8 * i), -1, "s2_wr");
    do_burst(CMD_READ, 22'd0, 1'b1, 22'd0, -1, "s2_starve_rd");
    do_burst(CMD_WRITE, 22'd153632, 1'b1, 22'd96, -1, "s2_wr_after");

    // frame_start at offset 0 does not count; mid-frame it does.
    apply_reset(8'd0, 8'd128);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    #1;
    check("s3_fs_at_zero", frames_dropped_a, 0);
    wr_used = 8'd200;
    for (int i = 0; i < 100; i++)
      do_burst(CMD_WRITE, 22'(153600 + 8 * i), 1'b0, 22'd0, -1, "s3_wr");
    wr_used = 8'd0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    check("s3_dropped", frames_dropped_a, 1);
    check("s3_dropped_b", frames_dropped_b, 1);
    wr_used = 8'd200;
    do_burst(CMD_WRITE, 22'd153600, 1'b0, 22'd0, -1, "s3_restart");
    do_burst(CMD_WRITE, 22'd153608, 1'b0, 22'd0, 3, "s3_fs_in_burst");
    do_burst(CMD_WRITE, 22'd153600, 1'b0, 22'd0, -1, "s3_restart2");
    check("s3_dropped2", frames_dropped_a, 2);

    // Frame wrap on dut_b: latest=1, write moves to buffer 2, display follows.
    apply_reset(8'd200, 8'd128);
    for (int i = 0; i < 8; i++)
      do_burst(CMD_WRITE, 22'(153600 + 8 * i), 1'b1, 22'(64 + 8 * i), -1, "s4_wr");
    do_burst(CMD_WRITE, 22'd153664, 1'b1, 22'd128, -1, "s4_wr_buf2");
    wr_used = 8'd0;
    rd_used = 8'd0;
    for (int i = 0; i < 8; i++)
      do_burst(CMD_READ, 22'(8 * i), 1'b1, 22'(8 * i), -1, "s4_rd");
    check("s4_rd_buffer_b", rd_buffer_b, 1);
    check("s4_rd_buffer_a", rd_buffer_a, 0);
    do_burst(CMD_READ, 22'd64, 1'b1, 22'd64, -1, "s4_rd_buf1");

    // frame_start on the last write of a frame (dut_b) versus mid-frame (dut_a).
    apply_reset(8'd200, 8'd128);
    for (int i = 0; i < 7; i++)
      do_burst(CMD_WRITE, 22'(153600 + 8 * i), 1'b1, 22'(64 + 8 * i), -1, "s5_wr");
    do_burst(CMD_WRITE, 22'd153656, 1'b1, 22'd120, 7, "s5_wr_last");
    check("s5_dropped_b", frames_dropped_b, 0);
    check("s5_dropped_a", frames_dropped_a, 1);
    do_burst(CMD_WRITE, 22'd153600, 1'b1, 22'd128, -1, "s5_wr_next");
    do_burst(CMD_WRITE, 22'd153608, 1'b1, 22'd136, -1, "s5_wr_next2");
    check("s5_dropped_b_after", frames_dropped_b, 0);

    // Reset on the third read word abandons the burst and clears offsets.
    apply_reset(8'd8, 8'd0);
    do_burst(CMD_WRITE, 22'd153600, 1'b1, 22'd64, -1, "s6_wr");
    wr_used = 8'd0;
    do_burst(CMD_READ, 22'd0, 1'b1, 22'd0, -1, "s6_rd");
    w = 0;
    while (command_a !== CMD_READ && w < 40) begin
      @(negedge clk);
      w++;
    end
    #1;
    check("s6_rd2_grant", command_a, CMD_READ);
    check("s6_rd2_addr", data_address_a, 8);
    for (int k = 0; k < 2; k++) begin
      data_read_valid = 1'b1;
      #1;
      check("s6_rd2_enable", rd_enable_a, 1);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("s6_rst_cycle_enable", rd_enable_a, 0);
    @(negedge clk);
    reset = 1'b0;
    wr_used = 8'd8;
    #1;
    check("s6_after_cmd", command_a, CMD_IDLE);
    check("s6_after_enable", rd_enable_a, 0);
    check("s6_after_addr", data_address_a, 0);
    data_read_valid = 1'b0;
    do_burst(CMD_WRITE, 22'd153600, 1'b1, 22'd64, -1, "s6_wr_off0");
    wr_used = 8'd0;
    do_burst(CMD_READ, 22'd0, 1'b1, 22'd0, -1, "s6_rd_off0");
    check("s6_rd_buffer", rd_buffer_a, 0);
    check("s6_dropped", frames_dropped_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
